// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer:
// slot state encoding, statistics counter width and the select range check.
// Optional feature macro used by the demux files: DEMUX_STATS_EN.
package demux_pkg;

  // One-entry slot occupancy; FULL maps directly onto the channel's y_valid bit.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Width of every statistics counter (drain counters and drop counter).
  localparam int STAT_W = 16;

  // True when a destination index addresses an existing channel.
  function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
    logic ok;
    if (sel < n) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel of the demultiplexer: a single-entry holding slot with
// its occupancy bit, data register and load/drain sequencing.
// With DEMUX_STATS_EN defined it also keeps a saturating count of drains.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             slot_valid,
  output logic [WIDTH-1:0] slot_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0] drain_cnt
`endif
);

  slot_state_t      state_r;
  logic [WIDTH-1:0] data_r;
  logic             drain_s;

  assign slot_valid = (state_r == SLOT_FULL);
  assign slot_data  = data_r;
  // A ready consumer facing an empty slot is not a drain.
  assign drain_s    = slot_valid & drain_ready;

  // Slot occupancy and data: a load always wins (it also covers a same-edge drain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SLOT_EMPTY;
      data_r  <= {WIDTH{1'b0}};
    end else if (load) begin
      state_r <= SLOT_FULL;
      data_r  <= load_data;
    end else if (drain_s) begin
      state_r <= SLOT_EMPTY;
      data_r  <= data_r;
    end else begin
      state_r <= state_r;
      data_r  <= data_r;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] drain_cnt_r;

  assign drain_cnt = drain_cnt_r;

  // Saturating drain counter; it sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_r <= {STAT_W{1'b0}};
    end else if (drain_s && (drain_cnt_r != {STAT_W{1'b1}})) begin
      drain_cnt_r <= drain_cnt_r + 16'd1;
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end
`endif

endmodule

// File: rtl/demux_1xn_reg.sv
// Registered 1-to-N demultiplexer with valid/ready handshake.
// A word is steered to the channel named by i_sel and parked in that
// channel's one-entry slot until the consumer takes it; channels stall
// independently. Out-of-range selects are swallowed and flagged on sel_err.
// Optional feature macro: DEMUX_STATS_EN adds stat_cnt and drop_cnt.
module demux_1xn_reg
  import demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [SEL_W-1:0]       i_sel,
  input  logic                   i_valid,
  output logic                   i_ready,
  output logic [N_OUT*WIDTH-1:0] y_data,
  output logic [N_OUT-1:0]       y_valid,
  input  logic [N_OUT-1:0]       y_ready,
  output logic                   sel_err
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_OUT*STAT_W-1:0] stat_cnt,
  output logic [STAT_W-1:0]       drop_cnt
`endif
);

  logic [31:0]      sel_idx_s;
  logic             in_range_s;
  logic [N_OUT-1:0] sel_hit_s;
  logic [N_OUT-1:0] slot_ready_s;
  logic [N_OUT-1:0] load_s;
  logic             drop_s;
  logic             sel_err_r;

  assign sel_idx_s  = 32'(i_sel);
  assign in_range_s = sel_in_range(sel_idx_s, 32'(N_OUT));

  // One-hot decode of the destination and per-channel "can take a word" flags.
  always_comb begin
    sel_hit_s    = {N_OUT{1'b0}};
    slot_ready_s = {N_OUT{1'b0}};
    for (int k = 0; k < N_OUT; k++) begin
      sel_hit_s[k]    = in_range_s & (sel_idx_s == 32'(k));
      slot_ready_s[k] = ~y_valid[k] | y_ready[k];
    end
  end

  // Input ready: the addressed slot's readiness, or always for a select that will be dropped.
  always_comb begin
    if (in_range_s) begin
      i_ready = |(sel_hit_s & slot_ready_s);
    end else begin
      i_ready = 1'b1;
    end
  end

  assign load_s = {N_OUT{i_valid & i_ready}} & sel_hit_s;
  assign drop_s = i_valid & ~in_range_s;
  assign sel_err = sel_err_r;

  // One-cycle error pulse for every word discarded because of a bad select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= drop_s;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] drop_cnt_r;

  assign drop_cnt = drop_cnt_r;

  // Saturating count of discarded words, advanced on the same edge that raises sel_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= {STAT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != {STAT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end
`endif

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_s[g]),
      .load_data  (i_data),
      .drain_ready(y_ready[g]),
      .slot_valid (y_valid[g]),
      .slot_data  (y_data[g*WIDTH +: WIDTH])
`ifdef DEMUX_STATS_EN
      ,
      .drain_cnt  (stat_cnt[g*STAT_W +: STAT_W])
`endif
    );
  end

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Self-checking bench for demux_1xn_reg: a 4-channel instance driven from a
// vector table and hand sequences, and a 3-channel instance (which can see
// out-of-range selects) driven randomly against a queue-based reference.
module tb_demux_1xn_reg;

  logic clk;
  logic rst_n;

  // 4-channel instance
  logic        v4;
  logic [1:0]  sel4;
  logic [7:0]  d4;
  logic        rdy4;
  logic [31:0] yd4;
  logic [3:0]  yv4;
  logic [3:0]  yr4;
  logic        err4;

  // 3-channel instance
  logic        v3;
  logic [1:0]  sel3;
  logic [7:0]  d3;
  logic        rdy3;
  logic [23:0] yd3;
  logic [2:0]  yv3;
  logic [2:0]  yr3;
  logic        err3;

`ifdef DEMUX_STATS_EN
  logic [63:0] stat4;
  logic [15:0] drop4;
  logic [47:0] stat3;
  logic [15:0] drop3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  demux_1xn_reg #(.WIDTH(8), .N_OUT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_data(d4), .i_sel(sel4), .i_valid(v4),
    .i_ready(rdy4), .y_data(yd4), .y_valid(yv4), .y_ready(yr4), .sel_err(err4)
`ifdef DEMUX_STATS_EN
    , .stat_cnt(stat4), .drop_cnt(drop4)
`endif
  );

  demux_1xn_reg #(.WIDTH(8), .N_OUT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_data(d3), .i_sel(sel3), .i_valid(v3),
    .i_ready(rdy3), .y_data(yd3), .y_valid(yv3), .y_ready(yr3), .sel_err(err3)
`ifdef DEMUX_STATS_EN
    , .stat_cnt(stat3), .drop_cnt(drop3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move from a negedge (inputs just driven) through the next rising edge to #1 after it.
  task automatic to_post_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] yr;
    logic       exp_rdy;
    logic [3:0] exp_yv;
    int         ch;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[12];

  // Reference model for the 3-channel instance: a queue per channel plus the last loaded word.
  logic [7:0] mq[3][$];
  logic [7:0] mlast[3];

  initial begin
    logic       exp_rdy;
    logic       exp_err;
    logic [2:0] exp_yv;

    // Stimulus table: drive, expected i_ready before the edge, expected y_valid/data after it.
    tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2, 8'hA5};
    tbl[1]  = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0110, 1, 8'h11};
    tbl[2]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 4'b0110, 1, 8'h11};
    tbl[3]  = '{1'b1, 2'd1, 8'h22, 4'b0010, 1'b1, 4'b0110, 1, 8'h22};
    tbl[4]  = '{1'b1, 2'd0, 8'hC0, 4'b0000, 1'b1, 4'b0111, 0, 8'hC0};
    tbl[5]  = '{1'b1, 2'd1, 8'h31, 4'b1110, 1'b1, 4'b0011, 1, 8'h31};
    tbl[6]  = '{1'b1, 2'd2, 8'h32, 4'b1110, 1'b1, 4'b0101, 2, 8'h32};
    tbl[7]  = '{1'b1, 2'd3, 8'h33, 4'b1110, 1'b1, 4'b1001, 3, 8'h33};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 4'b1110, 1'b0, 4'b0001, 0, 8'hC0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000, 0, 8'hC0};
    tbl[10] = '{1'b1, 2'd3, 8'h77, 4'b1111, 1'b1, 4'b1000, 3, 8'h77};
    tbl[11] = '{1'b0, 2'd3, 8'h00, 4'b0000, 1'b0, 4'b1000, 3, 8'h77};

    // Reset with random inputs on both instances.
    rst_n = 1'b0;
    v4 = 1'($urandom); sel4 = 2'($urandom); d4 = 8'($urandom); yr4 = 4'($urandom);
    v3 = 1'($urandom); sel3 = 2'($urandom); d3 = 8'($urandom); yr3 = 3'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("reset_yv4", 64'(yv4), 64'h0);
    check("reset_yd4", 64'(yd4), 64'h0);
    check("reset_err4", 64'(err4), 64'h0);
    check("reset_yv3", 64'(yv3), 64'h0);
    check("reset_err3", 64'(err3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b0; yr4 = 4'b0000;
    v3 = 1'b0; yr3 = 3'b000;

    // Table: first word after reset, backpressure, channel independence.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      v4 = tbl[i].v; sel4 = tbl[i].sel; d4 = tbl[i].d; yr4 = tbl[i].yr;
      #1;
      check($sformatf("tbl%0d_ready", i), 64'(rdy4), 64'(tbl[i].exp_rdy));
      to_post_edge();
      check($sformatf("tbl%0d_yvalid", i), 64'(yv4), 64'(tbl[i].exp_yv));
      check($sformatf("tbl%0d_ydata", i), 64'(yd4[tbl[i].ch*8 +: 8]), 64'(tbl[i].exp_d));
      check($sformatf("tbl%0d_selerr", i), 64'(err4), 64'h0);
    end

    // Full rate: 16 round-robin words with all consumers ready, one per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v4 = 1'b1; sel4 = 2'(i % 4); d4 = 8'(i); yr4 = 4'hF;
      #1;
      check($sformatf("rate%0d_ready", i), 64'(rdy4), 64'h1);
      to_post_edge();
      check($sformatf("rate%0d_yvalid", i), 64'(yv4), 64'(4'b0001 << (i % 4)));
      check($sformatf("rate%0d_ydata", i), 64'(yd4[(i % 4)*8 +: 8]), 64'(i));
    end
    @(negedge clk);
    v4 = 1'b0; yr4 = 4'hF;
    to_post_edge();
    check("rate_idle_yvalid", 64'(yv4), 64'h0);
    check("rate_hold_data", 64'(yd4), 64'h0F0E0D0C);

    // Out-of-range select on the 3-channel instance, with ch1 holding a word.
    @(negedge clk);
    v3 = 1'b1; sel3 = 2'd1; d3 = 8'h44; yr3 = 3'b000;
    to_post_edge();
    check("oor_pre_yvalid", 64'(yv3), 64'h2);
    @(negedge clk);
    v3 = 1'b1; sel3 = 2'd3; d3 = 8'hFF;
    #1;
    check("oor_ready", 64'(rdy3), 64'h1);
    to_post_edge();
    check("oor_selerr_high", 64'(err3), 64'h1);
    check("oor_yvalid", 64'(yv3), 64'h2);
    check("oor_ydata", 64'(yd3), 64'h004400);
    @(negedge clk);
    v3 = 1'b0;
    to_post_edge();
    check("oor_selerr_low", 64'(err3), 64'h0);
    check("oor_yvalid_after", 64'(yv3), 64'h2);
`ifdef DEMUX_STATS_EN
    check("oor_drop_cnt", 64'(drop3), 64'h1);
`endif

    // Asynchronous reset with every slot full.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v4 = 1'b1; sel4 = 2'(k); d4 = 8'(8'h50 + k); yr4 = 4'b0000;
      to_post_edge();
    end
    check("full_before_reset", 64'(yv4), 64'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_yv4", 64'(yv4), 64'h0);
    check("async_reset_yd4", 64'(yd4), 64'h0);
    check("async_reset_yv3", 64'(yv3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b1; sel4 = 2'd0; d4 = 8'h5A; yr4 = 4'b0000;
    to_post_edge();
    check("after_reset_yvalid", 64'(yv4), 64'h1);
    check("after_reset_ydata", 64'(yd4[7:0]), 64'h5A);
    @(negedge clk);
    v4 = 1'b0;

    // Random traffic on the 3-channel instance against the queue model.
    for (int k = 0; k < 3; k++) mlast[k] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      v3 = 1'($urandom); sel3 = 2'($urandom_range(0, 3)); d3 = 8'($urandom); yr3 = 3'($urandom);
      if (sel3 < 2'd3) exp_rdy = (mq[sel3].size() == 0) || yr3[sel3];
      else exp_rdy = 1'b1;
      #1;
      check($sformatf("rnd%0d_ready", n), 64'(rdy3), 64'(exp_rdy));
      for (int k = 0; k < 3; k++) begin
        if (mq[k].size() != 0 && yr3[k]) void'(mq[k].pop_front());
      end
      if (v3 && exp_rdy && sel3 < 2'd3) begin
        mq[sel3].push_back(d3);
        mlast[sel3] = d3;
      end
      exp_err = v3 && (sel3 == 2'd3);
      to_post_edge();
      for (int k = 0; k < 3; k++) exp_yv[k] = (mq[k].size() != 0);
      check($sformatf("rnd%0d_yvalid", n), 64'(yv3), 64'(exp_yv));
      check($sformatf("rnd%0d_selerr", n), 64'(err3), 64'(exp_err));
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rnd%0d_ydata%0d", n, k), 64'(yd3[k*8 +: 8]), 64'(mlast[k]));
      end
    end
    @(negedge clk);
    v3 = 1'b0;

`ifdef DEMUX_STATS_EN
    // Drain counter saturation: continuous load and drain on channel 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b1; sel4 = 2'd0; d4 = 8'h01; yr4 = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    check("stat_cnt0_sat", 64'(stat4[15:0]), 64'hFFFF);
    check("stat_cnt1_zero", 64'(stat4[31:16]), 64'h0);
    @(negedge clk);
    v4 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
